audio_pdm_rx: RTL and testbench

//  Audio capture path; the input-side counterpart of the PWM output peripheral.

---
 rtl/audio_pdm_rx.sv | 175 +++++++++++++++++
 tb/tb_audio_pdm_rx.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_pdm_rx.sv
// PDM microphone receiver: drives the mic clock, decimates the 1-bit stream by
// counting ones per window and buffers samples in a small FIFO read over the bus.
module audio_pdm_rx #(
    parameter int CLK_DIV    = 16,
    parameter int DECIM      = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pdm_i,
    output logic        pdm_clk_o,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    input  logic        re_i,
    input  logic        addr_i,
    output logic [31:0] rdata_o,
    output logic        irq
);

    localparam int SW = $clog2(DECIM + 1);
    localparam int BW = $clog2(DECIM);
    localparam int DW = $clog2(CLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic          pdm_meta;
    logic          pdm_sync;
    logic [DW-1:0] div_cnt;
    logic          pdm_clk_q;
    logic [BW-1:0] bit_cnt;
    logic [SW-1:0] ones_acc;
    logic          enable;
    logic [3:0]    threshold;
    logic          overflow;
    logic [SW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          irq_q;

    logic          div_wrap;
    logic          capture;
    logic          window_end;
    logic [SW-1:0] sample;
    logic          empty;
    logic          full;
    logic          do_pop;
    logic          do_push;
    logic          ovf_event;

    // The mic changes data after our rising edge, so the falling edge is the safe capture point
    assign div_wrap   = enable && (div_cnt == DW'(CLK_DIV - 1));
    assign capture    = div_wrap && pdm_clk_q;
    assign window_end = capture && (bit_cnt == BW'(DECIM - 1));
    assign sample     = ones_acc + SW'(pdm_sync);
    assign empty      = (count == '0);
    assign full       = (count == CW'(FIFO_DEPTH));
    assign do_pop     = re_i && !addr_i && !empty;
    assign do_push    = window_end && (!full || do_pop);
    assign ovf_event  = window_end && full && !do_pop;
    assign pdm_clk_o  = pdm_clk_q;
    assign irq        = irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pdm_meta <= 1'b0;
            pdm_sync <= 1'b0;
        end else begin
            pdm_meta <= pdm_i;
            pdm_sync <= pdm_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            pdm_clk_q <= 1'b0;
        end else if (!enable) begin
            div_cnt   <= '0;
            pdm_clk_q <= 1'b0;
        end else if (div_wrap) begin
            div_cnt   <= '0;
            pdm_clk_q <= ~pdm_clk_q;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Holding the window cleared while disabled discards any partial window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            ones_acc <= '0;
        end else if (!enable) begin
            bit_cnt  <= '0;
            ones_acc <= '0;
        end else if (capture) begin
            if (window_end) begin
                bit_cnt  <= '0;
                ones_acc <= '0;
            end else begin
                bit_cnt  <= bit_cnt + 1'b1;
                ones_acc <= sample;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable    <= 1'b0;
            threshold <= '0;
            overflow  <= 1'b0;
        end else begin
            if (we_i) begin
                enable    <= wdata_i[0];
                threshold <= wdata_i[11:8];
            end
            if (ovf_event) begin
                overflow <= 1'b1;
            end else if (we_i && wdata_i[1]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= sample;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Registered so the interrupt line never glitches while count settles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= enable && (threshold != '0) && (5'(count) >= 5'(threshold));
        end
    end

    always_comb begin
        rdata_o = '0;
        if (addr_i) begin
            rdata_o[0]     = enable;
            rdata_o[1]     = overflow;
            rdata_o[2]     = empty;
            rdata_o[3]     = full;
            rdata_o[15:8]  = 8'(count);
            rdata_o[19:16] = threshold;
        end else if (!empty) begin
            rdata_o = 32'(mem[rd_ptr]);
        end
    end

endmodule

// File: tb/tb_audio_pdm_rx.sv
// Directed-random bench for audio_pdm_rx: drives PDM bits like a microphone and
// compares bus reads against a queue-based model of windows, FIFO and status.
module tb_audio_pdm_rx;

    localparam int CLK_DIV    = 16;
    localparam int DECIM      = 64;
    localparam int FIFO_DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pdm_i;
    logic        pdm_clk_o;
    logic        we_i;
    logic [31:0] wdata_i;
    logic        re_i;
    logic        addr_i;
    logic [31:0] rdata_o;
    logic        irq;

    int          n_checks = 0;
    int          n_fail = 0;
    bit          timed_out = 1'b0;

    logic [31:0] exp_q[$];
    logic        m_en = 1'b0;
    logic        m_ovf = 1'b0;
    logic [3:0]  m_thr = 4'h0;

    audio_pdm_rx #(
        .CLK_DIV    (CLK_DIV),
        .DECIM      (DECIM),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pdm_i     (pdm_i),
        .pdm_clk_o (pdm_clk_o),
        .we_i      (we_i),
        .wdata_i   (wdata_i),
        .re_i      (re_i),
        .addr_i    (addr_i),
        .rdata_o   (rdata_o),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int c;
        c = exp_q.size();
        return {12'h000, m_thr, 8'(c), 4'h0, (c == FIFO_DEPTH), (c == 0), m_ovf, m_en};
    endfunction

    function automatic logic [31:0] exp_head();
        return (exp_q.size() > 0) ? exp_q[0] : 32'h0;
    endfunction

    // A finished window lands in the FIFO unless it is full, in which case it is lost
    task automatic model_push(input int ones);
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(32'(ones));
        else m_ovf = 1'b1;
    endtask

    task automatic wait_level(input logic v);
        int n;
        if (timed_out) return;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (pdm_clk_o !== v && n < 4 * CLK_DIV);
        if (pdm_clk_o !== v) begin
            timed_out = 1'b1;
            check("pdm_clk_timeout", 32'(pdm_clk_o), 32'(v));
        end
    endtask

    task automatic write_ctrl(input logic [31:0] d);
        @(negedge clk);
        we_i    = 1'b1;
        wdata_i = d;
        @(posedge clk);
        #1;
        we_i = 1'b0;
        m_en  = d[0];
        m_thr = d[11:8];
        if (d[1]) m_ovf = 1'b0;
    endtask

    task automatic read_status(input string tag);
        @(negedge clk);
        addr_i = 1'b1;
        #1;
        check(tag, rdata_o, exp_status());
        addr_i = 1'b0;
    endtask

    task automatic read_data(input string tag);
        @(negedge clk);
        addr_i = 1'b0;
        re_i   = 1'b1;
        #1;
        check(tag, rdata_o, exp_head());
        @(posedge clk);
        #1;
        re_i = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    // mode 0 = random, 1 = all ones, 2 = alternating starting with 1
    task automatic send_bits(input int nbits, input int mode, input bit pop_last);
        int          ones;
        logic        b;
        logic [31:0] got;
        ones = 0;
        for (int i = 0; i < nbits; i++) begin
            case (mode)
                0:       b = 1'($urandom_range(0, 1));
                1:       b = 1'b1;
                default: b = (i % 2 == 0);
            endcase
            ones += int'(b);
            wait_level(1'b1);
            pdm_i = b;
            if (pop_last && i == nbits - 1) begin
                repeat (CLK_DIV - 1) @(posedge clk);
                #1;
                re_i   = 1'b1;
                addr_i = 1'b0;
                #1;
                got = rdata_o;
                @(posedge clk);
                #1;
                re_i = 1'b0;
                check("pop_push_pdm_clk_fell", 32'(pdm_clk_o), 32'h0);
                check("pop_push_head", got, exp_head());
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end else begin
                wait_level(1'b0);
            end
        end
        if (nbits == DECIM) model_push(ones);
    endtask

    initial begin
        rst_n   = 1'b0;
        pdm_i   = 1'b0;
        we_i    = 1'b0;
        wdata_i = '0;
        re_i    = 1'b0;
        addr_i  = 1'b0;

        // Reset held while the data line toggles
        repeat (6) begin
            @(posedge clk);
            pdm_i = ~pdm_i;
        end
        #1;
        check("reset_pdm_clk", 32'(pdm_clk_o), 32'h0);
        check("reset_irq", 32'(irq), 32'h0);
        addr_i = 1'b1;
        #1;
        check("reset_status", rdata_o, 32'h0000_0004);
        addr_i = 1'b0;
        #1;
        check("reset_data", rdata_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        read_status("status_after_reset");

        // Constant ones gives a full-scale sample
        write_ctrl(32'h1);
        send_bits(DECIM, 1, 1'b0);
        read_status("status_one_sample");
        read_data("data_all_ones");
        read_status("status_empty_after_pop");

        // Alternating bits gives half scale
        send_bits(DECIM, 2, 1'b0);
        send_bits(DECIM, 2, 1'b0);
        read_data("data_alt_0");
        read_data("data_alt_1");
        read_status("status_alt_drained");

        // Nine unread windows overflow the FIFO
        for (int w = 0; w < FIFO_DEPTH + 1; w++) send_bits(DECIM, 0, 1'b0);
        read_status("status_overflow_full");
        check("irq_off_thr0", 32'(irq), 32'h0);
        write_ctrl(32'h3);
        read_status("status_ovf_cleared");

        // Pop and push on the same edge while full
        send_bits(DECIM, 0, 1'b1);
        read_status("status_pop_push_full");
        write_ctrl(32'h0);
        read_status("status_disabled_full");
        for (int k = 0; k < FIFO_DEPTH; k++) read_data($sformatf("drain_full_%0d", k));
        read_data("data_empty_read");
        read_status("status_empty_read");

        // Threshold interrupt
        write_ctrl(32'h401);
        for (int w = 0; w < 3; w++) send_bits(DECIM, 0, 1'b0);
        check("irq_below_thr", 32'(irq), 32'h0);
        send_bits(DECIM, 0, 1'b0);
        check("irq_lags_push", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        check("irq_at_thr", 32'(irq), 32'h1);
        read_data("data_irq_pop");
        check("irq_lags_pop", 32'(irq), 32'h1);
        @(posedge clk);
        #1;
        check("irq_below_after_pop", 32'(irq), 32'h0);
        read_status("status_thr_count3");
        write_ctrl(32'h0);
        for (int k = 0; k < 3; k++) read_data($sformatf("drain_irq_%0d", k));

        // Partial window discarded on disable
        write_ctrl(32'h1);
        send_bits(30, 0, 1'b0);
        write_ctrl(32'h0);
        write_ctrl(32'h1);
        send_bits(DECIM, 1, 1'b0);
        read_status("status_after_reenable");
        read_data("data_fresh_window");

        // Asynchronous reset mid-operation
        send_bits(DECIM, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_en  = 1'b0;
        m_ovf = 1'b0;
        m_thr = 4'h0;
        addr_i = 1'b1;
        #1;
        check("midreset_status", rdata_o, exp_status());
        check("midreset_pdm_clk", 32'(pdm_clk_o), 32'h0);
        addr_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
